// File: rtl/tex_agent_pkg.sv
// tex_agent_pkg: shared metadata type, defaults and free-tag encoder for tex_agent
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NTEX_BITS
`define NTEX_BITS 1
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

package tex_agent_pkg;
    localparam int MAX_PENDING_DEF = 4;

    typedef struct packed {
        logic [`NW_BITS-1:0]   wid;
        logic [31:0]           pc;
        logic [`NR_BITS-1:0]   rd;
        logic                  wb;
        logic [`UUID_BITS-1:0] uuid;
    } tex_meta_t;

    function automatic logic [3:0] lowest_free(input logic [15:0] mask);
        lowest_free = '0;
        for (int i = 15; i >= 0; i--)
            if (mask[i]) lowest_free = 4'(i);
    endfunction
endpackage

// File: rtl/tex_agent_tag_table.sv
// tex_agent_tag_table: free mask and per-tag writeback metadata for outstanding TEX requests
module tex_agent_tag_table
    import tex_agent_pkg::*;
#(
    parameter int MAX_PENDING = MAX_PENDING_DEF,
    parameter int TAG_W       = $clog2(MAX_PENDING)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_en,
    input  tex_meta_t              alloc_data,
    output logic [TAG_W-1:0]       alloc_tag,
    output logic                   alloc_full,
    input  logic [TAG_W-1:0]       lookup_tag,
    output tex_meta_t              lookup_data,
    input  logic                   release_en,
    input  logic [TAG_W-1:0]       release_tag,
    output logic [MAX_PENDING-1:0] free
);
    tex_meta_t meta [MAX_PENDING];

    assign alloc_tag   = TAG_W'(lowest_free(16'(free)));
    assign alloc_full  = free == '0;
    assign lookup_data = meta[lookup_tag];

    always_ff @(posedge clk) begin
        if (reset) begin
            free <= '1;
        end else begin
            if (alloc_en) free[alloc_tag] <= 1'b0;
            if (release_en) free[release_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (alloc_en) meta[alloc_tag] <= alloc_data;
endmodule

// File: rtl/tex_agent.sv
// tex_agent: tagged TEX request issue, out-of-order response matching and commit; TEX_AGENT_PERF_EN adds perf counters
module tex_agent
    import tex_agent_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int NUM_REQS    = `NUM_THREADS,
    parameter int MAX_PENDING = MAX_PENDING_DEF,
    parameter int TAG_W       = $clog2(MAX_PENDING)
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef TEX_AGENT_PERF_EN
    output logic [`PERF_CTR_BITS-1:0] perf_stalls,
    output logic [TAG_W:0]          perf_pending,
`endif
    input  logic                    exe_valid,
    output logic                    exe_ready,
    input  logic [NUM_REQS-1:0]     exe_tmask,
    input  logic [`NW_BITS-1:0]     exe_wid,
    input  logic [31:0]             exe_PC,
    input  logic [`NR_BITS-1:0]     exe_rd,
    input  logic                    exe_wb,
    input  logic [`UUID_BITS-1:0]   exe_uuid,
    input  logic [`NTEX_BITS-1:0]   exe_unit,
    input  logic [2*NUM_REQS*32-1:0] exe_coords,
    input  logic [NUM_REQS*32-1:0]  exe_lod,
    output logic                    tex_req_valid,
    input  logic                    tex_req_ready,
    output logic [NUM_REQS-1:0]     tex_req_tmask,
    output logic [`NTEX_BITS-1:0]   tex_req_unit,
    output logic [2*NUM_REQS*32-1:0] tex_req_coords,
    output logic [NUM_REQS*32-1:0]  tex_req_lod,
    output logic [`UUID_BITS-1:0]   tex_req_uuid,
    output logic [TAG_W-1:0]        tex_req_tag,
    input  logic                    tex_rsp_valid,
    output logic                    tex_rsp_ready,
    input  logic [TAG_W-1:0]        tex_rsp_tag,
    input  logic [NUM_REQS-1:0]     tex_rsp_tmask,
    input  logic [NUM_REQS*32-1:0]  tex_rsp_data,
    output logic                    commit_valid,
    input  logic                    commit_ready,
    output logic [`NW_BITS-1:0]     commit_wid,
    output logic [31:0]             commit_PC,
    output logic [`NR_BITS-1:0]     commit_rd,
    output logic                    commit_wb,
    output logic [`UUID_BITS-1:0]   commit_uuid,
    output logic [NUM_REQS-1:0]     commit_tmask,
    output logic [NUM_REQS*32-1:0]  commit_data,
    output logic                    commit_eop
);
    logic                   exe_fire, rsp_fire, commit_fire, alloc_full;
    logic [TAG_W-1:0]       alloc_tag, commit_tag;
    logic [MAX_PENDING-1:0] free;
    tex_meta_t              rsp_meta;

    // tags are released on commit, so a full table stays full for the cycle a commit fires
    assign exe_ready     = !reset && !alloc_full && (!tex_req_valid || tex_req_ready);
    assign exe_fire      = exe_valid && exe_ready;
    assign tex_rsp_ready = !commit_valid || commit_ready;
    assign rsp_fire      = tex_rsp_valid && tex_rsp_ready;
    assign commit_fire   = commit_valid && commit_ready;
    assign commit_eop    = 1'b1;

    tex_agent_tag_table #(.MAX_PENDING(MAX_PENDING), .TAG_W(TAG_W)) tag_table (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (exe_fire),
        .alloc_data ('{wid: exe_wid, pc: exe_PC, rd: exe_rd, wb: exe_wb, uuid: exe_uuid}),
        .alloc_tag  (alloc_tag),
        .alloc_full (alloc_full),
        .lookup_tag (tex_rsp_tag),
        .lookup_data(rsp_meta),
        .release_en (commit_fire),
        .release_tag(commit_tag),
        .free       (free)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tex_req_valid  <= 1'b0;
            tex_req_tmask  <= '0;
            tex_req_unit   <= '0;
            tex_req_coords <= '0;
            tex_req_lod    <= '0;
            tex_req_uuid   <= '0;
            tex_req_tag    <= '0;
        end else if (exe_fire) begin
            tex_req_valid  <= 1'b1;
            tex_req_tmask  <= exe_tmask;
            tex_req_unit   <= exe_unit;
            tex_req_coords <= exe_coords;
            tex_req_lod    <= exe_lod;
            tex_req_uuid   <= exe_uuid;
            tex_req_tag    <= alloc_tag;
        end else if (tex_req_ready) begin
            tex_req_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid <= 1'b0;
            commit_wid   <= '0;
            commit_PC    <= '0;
            commit_rd    <= '0;
            commit_wb    <= 1'b0;
            commit_uuid  <= '0;
            commit_tmask <= '0;
            commit_data  <= '0;
            commit_tag   <= '0;
        end else if (rsp_fire) begin
            commit_valid <= 1'b1;
            commit_wid   <= rsp_meta.wid;
            commit_PC    <= rsp_meta.pc;
            commit_rd    <= rsp_meta.rd;
            commit_wb    <= rsp_meta.wb;
            commit_uuid  <= rsp_meta.uuid;
            commit_tmask <= tex_rsp_tmask;
            commit_data  <= tex_rsp_data;
            commit_tag   <= tex_rsp_tag;
        end else if (commit_ready) begin
            commit_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(rsp_fire && free[tex_rsp_tag]))
                else $error("tex_agent%0d: response on unallocated tag %0d", CORE_ID, tex_rsp_tag);
            assert (!(exe_fire && exe_tmask == '0))
                else $error("tex_agent%0d: TEX issued with empty thread mask", CORE_ID);
        end
    end

`ifdef TEX_AGENT_PERF_EN
    localparam int PW = TAG_W + 1;

    always_ff @(posedge clk) begin
        if (reset) perf_stalls <= '0;
        else if (exe_valid && !exe_ready) perf_stalls <= perf_stalls + 1'b1;
    end

    assign perf_pending = PW'($countones(~free));
`endif
endmodule
